// File: rtl/tracked_ram_pkg.sv
// Shared defaults for the tracked scratch RAM; used by the lab top and its bench.
package tracked_ram_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 3;

endpackage

// File: rtl/tracked_ram_sdp_ram.sv
// Simple-dual-port storage array with a registered read port; deliberately not reset.
module sdp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Nonblocking update gives read-before-write on a shared address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tracked_ram.sv
// Dual-port scratch RAM with per-slot valid bits, occupancy count and full/empty flags.
module tracked_ram
    import tracked_ram_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_release,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_miss,
    output logic              wr_overwrite,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  valid_next;
    logic [ADDR_W:0]   count_next;
    logic [DATA_W-1:0] ram_q;
    logic              show_data;
    logic              wr_act;
    logic              rd_act;
    logic              rd_hit;
    logic              release_hit;
    logic              same_addr;
    logic              inc;
    logic              dec;

    assign wr_act      = wr_en & ~clr;
    assign rd_act      = rd_en & ~clr;
    assign rd_hit      = rd_act & valid[rd_addr];
    assign release_hit = rd_hit & rd_release;
    assign same_addr   = wr_addr == rd_addr;
    assign inc         = wr_act & ~valid[wr_addr];
    assign dec         = release_hit & ~(wr_act & same_addr);

    sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_act),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_act),
        .rd_addr (rd_addr),
        .rd_q    (ram_q)
    );

    // Write is applied after release so a same-address write leaves the slot valid.
    always_comb begin
        valid_next = valid;
        count_next = count + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        if (clr) begin
            valid_next = '0;
            count_next = '0;
        end else begin
            if (release_hit) begin
                valid_next[rd_addr] = 1'b0;
            end
            if (wr_act) begin
                valid_next[wr_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid        <= '0;
            count        <= '0;
            show_data    <= 1'b0;
            rd_valid     <= 1'b0;
            rd_miss      <= 1'b0;
            wr_overwrite <= 1'b0;
        end else begin
            valid        <= valid_next;
            count        <= count_next;
            rd_valid     <= rd_hit;
            rd_miss      <= rd_act & ~valid[rd_addr];
            wr_overwrite <= wr_act & valid[wr_addr] & ~(release_hit & same_addr);
            if (rd_act) begin
                show_data <= valid[rd_addr];
            end
        end
    end

    // The unreset array output is masked to zero until a hit has been captured.
    assign rd_data = show_data ? ram_q : '0;
    assign full    = count == (ADDR_W+1)'(DEPTH);
    assign empty   = count == '0;

endmodule

// File: tb/tb_tracked_ram.sv
// Self-checking bench for tracked_ram: directed plan steps, then random traffic against a slot model.
module tb_tracked_ram;
    import tracked_ram_pkg::*;

    localparam int DW    = DEFAULT_DATA_W;
    localparam int AW    = DEFAULT_ADDR_W;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          rd_release;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_miss;
    logic          wr_overwrite;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_valid [DEPTH];
    logic [DW-1:0] e_rd_data;
    bit            e_rd_valid;
    bit            e_rd_miss;
    bit            e_wr_ow;

    tracked_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_release   (rd_release),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_miss      (rd_miss),
        .wr_overwrite (wr_overwrite),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int liveSlots();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_valid[i] ? 1 : 0;
        return n;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        e_rd_data  = '0;
        e_rd_valid = 0;
        e_rd_miss  = 0;
        e_wr_ow    = 0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'(e_rd_data));
        checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_rd_valid));
        checkOutput({tag, ".rd_miss"}, 32'(rd_miss), 32'(e_rd_miss));
        checkOutput({tag, ".wr_ow"}, 32'(wr_overwrite), 32'(e_wr_ow));
        checkOutput({tag, ".count"}, 32'(count), 32'(liveSlots()));
        checkOutput({tag, ".full"}, 32'(full), 32'(liveSlots() == DEPTH));
        checkOutput({tag, ".empty"}, 32'(empty), 32'(liveSlots() == 0));
    endtask

    // Model works at the slot level: occupancy is simply the number of live slots.
    task automatic applyStimulus(input bit c, input bit we, input int wa, input int wd,
                                 input bit re, input bit rr, input int ra, input string tag);
        bit consumed;
        clr        = c;
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = DW'(wd);
        rd_en      = re;
        rd_release = rr;
        rd_addr    = AW'(ra);
        if (c) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
            e_rd_valid = 0;
            e_rd_miss  = 0;
            e_wr_ow    = 0;
        end else begin
            consumed   = re && rr && m_valid[ra];
            e_rd_valid = re && m_valid[ra];
            e_rd_miss  = re && !m_valid[ra];
            if (re) e_rd_data = m_valid[ra] ? m_mem[ra] : '0;
            e_wr_ow    = we && m_valid[wa] && !(consumed && wa == ra);
            if (consumed) m_valid[ra] = 0;
            if (we) begin
                m_valid[wa] = 1;
                m_mem[wa]   = DW'(wd);
            end
        end
        @(posedge clk);
        #1;
        checkAll(tag);
        clr        = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_release = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        clr        = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_en      = 1'b0;
        rd_release = 1'b0;
        rd_addr    = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "idle");

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1, i, 'hA0 + i, 0, 0, 0, "fill");
            checkOutput("fill.count_step", 32'(count), 32'(i + 1));
        end
        checkOutput("fill.full", 32'(full), 32'd1);
        applyStimulus(0, 1, 3, 'h55, 0, 0, 0, "rewrite3");
        checkOutput("rewrite3.ow", 32'(wr_overwrite), 32'd1);

        applyStimulus(0, 0, 0, 0, 1, 0, 3, "read3");
        checkOutput("read3.data", 32'(rd_data), 32'h55);
        applyStimulus(0, 0, 0, 0, 1, 1, 3, "release3");
        checkOutput("release3.count", 32'(count), 32'd7);
        applyStimulus(0, 0, 0, 0, 1, 0, 3, "reread3");
        checkOutput("reread3.miss", 32'(rd_miss), 32'd1);

        applyStimulus(0, 1, 5, 'h11, 1, 1, 5, "wr_rel5");
        checkOutput("wr_rel5.data", 32'(rd_data), 32'hA5);
        checkOutput("wr_rel5.count", 32'(count), 32'd7);
        applyStimulus(0, 0, 0, 0, 1, 0, 5, "read5");
        checkOutput("read5.data", 32'(rd_data), 32'h11);

        applyStimulus(1, 1, 3, 'h77, 0, 0, 0, "clr_wr3");
        checkOutput("clr_wr3.empty", 32'(empty), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 0, 3, "after_clr3");
        checkOutput("after_clr3.miss", 32'(rd_miss), 32'd1);

        for (int i = 0; i < 6; i++) applyStimulus(0, 1, i, 'h30 + i, 0, 0, 0, "refill");
        applyStimulus(0, 0, 0, 0, 1, 0, 2, "pre_areset");
        checkOutput("pre_areset.count", 32'(count), 32'd6);
        #3;
        reset = 1'b1;
        modelReset();
        #1;
        checkAll("areset");
        checkOutput("areset.count0", 32'(count), 32'd0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i += 3) applyStimulus(0, 0, 0, 0, 1, 0, i, "post_areset");

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 24) == 0, 1'($urandom), int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, DEPTH - 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tracked_ram.md
Name: tracked_ram

Overview:
- Parametrised simple-dual-port memory with per-entry valid tracking, an occupancy counter and full/empty flags.
- One write port and one read port operate in the same cycle.
- Reads can optionally consume (release) an entry.
- Serves as a small scratch/slot store in datapath labs wherever software needs to know which slots hold live data.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all tracking state.
- clr  in  1  synchronous clear of all valid bits.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_release  in  1  with rd_en: invalidate the entry after reading it.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  pulse: rd_data holds live data from the previous-cycle read.
- rd_miss  out  1  pulse: previous-cycle read targeted an invalid entry.
- wr_overwrite  out  1  pulse: previous-cycle write replaced a valid entry.
- count  out  ADDR_W+1  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, any time, including mid-operation):
  - valid bitmap = 0, count = 0, rd_data = 0.
  - rd_valid, rd_miss and wr_overwrite = 0.
  - empty = 1, full = 0.
  - Storage array is NOT reset; valid bits gate all visibility.
- full and empty decode combinationally from the count register only.
- Priority per cycle: reset > clr > normal operation.
- clr:
  - Next edge: valid bitmap = 0, count = 0.
  - Any wr_en or rd_en in the same cycle is ignored; the next cycle shows rd_valid = rd_miss = wr_overwrite = 0.
- Read, 1-cycle latency:
  - The decision uses valid[rd_addr] as it stood before the edge.
  - Valid entry: rd_data <= mem[rd_addr], rd_valid = 1, rd_miss = 0.
  - Invalid entry: rd_data <= 0, rd_valid = 0, rd_miss = 1.
  - No read: rd_data holds its value; rd_valid and rd_miss = 0.
- Read/write to the same address in one cycle: read-before-write; rd_data returns the old contents.
- Write:
  - mem[wr_addr] <= wr_data and valid[wr_addr] <= 1.
  - wr_overwrite = 1 next cycle iff the entry was already valid.
- Release (rd_en & rd_release on a valid entry): valid[rd_addr] <= 0.
  - rd_release without rd_en is ignored.
  - Release of an invalid entry is a no-op (rd_miss flags it).
- Release and write to the same address in one cycle:
  - Write wins; entry ends valid.
  - wr_overwrite = 0, because the old data was consumed.
- Count update: count_next = count + inc − dec.
  - inc = write to a previously invalid entry.
  - dec = release of a valid entry whose address differs from a concurrent write's address.
  - Same-address release+write on a valid entry: net 0.
  - Result never leaves 0..DEPTH.
- Full: writes to invalid entries are impossible by construction; writes are always overwrites, so no stall is required.
- Empty: every read misses.

Decomposition:
- Shared package/include holds the default DATA_W/ADDR_W values, used by the lab top and the bench.
- One natural sub-module: sdp_ram.
  - Storage array with registered read port, no reset.
  - Instantiated by tracked_ram.
  - Valid bitmap, counter and flags stay in the parent.

Test Plan:
1. Reset, then idle -> count = 0, empty = 1, full = 0, rd_valid = rd_miss = wr_overwrite = 0, rd_data = 0x00.
2. Write 0xA0+i to addresses 0..7 on consecutive cycles -> count steps 1..8, full = 1 after the 8th edge. Rewrite addr 3 = 0x55 -> wr_overwrite = 1, count stays 8.
3. Read addr 3 without release -> next cycle rd_data = 0x55, rd_valid = 1. Read addr 3 with release -> rd_data = 0x55, count = 7, full = 0. Read addr 3 again -> rd_miss = 1, rd_data = 0x00.
4. Same cycle: write addr 5 = 0x11 and release-read addr 5 (was 0xA5) -> rd_data = 0xA5, wr_overwrite = 0, count unchanged, later read of addr 5 = 0x11.
5. clr asserted together with a write to free addr 3 -> count = 0, empty = 1, write ignored; a following read of addr 3 gives rd_miss = 1.
6. Assert reset asynchronously between clock edges while count = 6 -> count, flags and pulses clear immediately without waiting for clk; a subsequent read of any address misses.
